// File: rtl/rv_test_ctrl.sv
// Compliance-run controller for the RV32I core: sequences core reset, snoops
// signature/halt stores, buffers signature words and reports run status.
module rv_test_ctrl #(
  parameter logic [31:0] SIG_ADDR   = 32'h0000_0F00,
  parameter logic [31:0] HALT_ADDR  = 32'hCAFE_BEEF,
  parameter int unsigned TIMEOUT    = 500000,
  parameter int unsigned RST_CYCLES = 10,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        core_rst,
  input  logic        st_en,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  output logic        sig_valid,
  input  logic        sig_ready,
  output logic [31:0] sig_data,
  output logic        done,
  output logic        timeout,
  output logic        overflow,
  output logic [31:0] cycle_cnt,
  output logic [15:0] sig_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [31:0]   TO_C = 32'(TIMEOUT);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q;
  logic            core_rst_q, done_q, timeout_q, overflow_q;
  logic [31:0]     cycle_cnt_q;
  logic [15:0]     sig_count_q;
  logic [HW-1:0]   hold_cnt_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic [31:0]     mem_q [FIFO_DEPTH];

  logic in_run, halt_hit, tmo_hit, sig_hit, full, pop, push, drop;

  always_comb begin
    in_run   = (state_q == S_RUN);
    halt_hit = in_run && st_en && (st_addr == HALT_ADDR);
    tmo_hit  = in_run && ((cycle_cnt_q + 32'd1) == TO_C);
    // Halt takes priority when the signature and halt addresses coincide.
    sig_hit  = in_run && st_en && (st_addr == SIG_ADDR) && !halt_hit;
    full     = (count_q == DEPTH_C);
    pop      = (count_q != '0) && sig_ready;
    push     = sig_hit && (!full || pop);
    drop     = sig_hit && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      core_rst_q  <= 1'b1;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      overflow_q  <= 1'b0;
      cycle_cnt_q <= '0;
      sig_count_q <= '0;
      hold_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (push && (sig_count_q != 16'hFFFF)) sig_count_q <= sig_count_q + 16'd1;
      if (drop) overflow_q <= 1'b1;

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_HOLD;
            core_rst_q  <= 1'b1;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
            cycle_cnt_q <= '0;
            sig_count_q <= '0;
            hold_cnt_q  <= '0;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= S_RUN;
            core_rst_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
          end
        end
        S_RUN: begin
          cycle_cnt_q <= cycle_cnt_q + 32'd1;
          if (halt_hit || tmo_hit) begin
            state_q    <= S_DRAIN;
            core_rst_q <= 1'b1;
            timeout_q  <= !halt_hit;
          end
        end
        S_DRAIN: begin
          if (count_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Storage is data only; occupancy is tracked by the reset-controlled pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= st_data;
  end

  assign sig_valid = (count_q != '0);
  assign sig_data  = sig_valid ? mem_q[rd_ptr_q] : 32'd0;
  assign core_rst  = core_rst_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign overflow  = overflow_q;
  assign cycle_cnt = cycle_cnt_q;
  assign sig_count = sig_count_q;

endmodule
